// File: rtl/fec_encoder.sv
// Rate-1/2 K=7 tail-biting convolutional encoder (G1=171, G2=133).
// Ping-pong block buffers decouple the serial input from the coded output.
module fec_encoder #(
  parameter int N_BLK = 96
) (
  input  logic clk,
  input  logic rst,
  input  logic Valid_in,
  input  logic Data_in,
  output logic Ready_out,
  input  logic Ready_in,
  output logic Valid_out,
  output logic Data_out
);

  localparam int CW = $clog2(N_BLK);
  localparam logic [CW-1:0] LAST = CW'(N_BLK - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t state_q, state_d;
  logic [1:0][N_BLK-1:0] buf_q, buf_d;
  logic [1:0] full_q, full_d;
  logic fsel_q, fsel_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic rsel_q, rsel_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic ph_q, ph_d;
  logic [5:0] sr_q, sr_d;
  logic vld_q, vld_d;
  logic dat_q, dat_d;

  logic accept, fill_done, rd_done, xfer, other_full;
  logic [N_BLK-1:0] rd_buf;
  logic [CW-1:0] rcnt_nx;
  logic cur_u, nxt_u;
  logic [5:0] ld_sr, nxt_sr;
  logic [1:0] ld_xy, cur_xy, nxt_xy;

  // {X,Y} for current bit u and history s (s[0]=s1 .. s[5]=s6)
  function automatic logic [1:0] enc(input logic u, input logic [5:0] s);
    logic [1:0] r;
    r[1] = u ^ s[0] ^ s[1] ^ s[2] ^ s[5];
    r[0] = u ^ s[1] ^ s[2] ^ s[4] ^ s[5];
    return r;
  endfunction

  assign Ready_out = !rst && !full_q[fsel_q];
  assign Valid_out = vld_q;
  assign Data_out  = dat_q;

  // Fill side: capture accepted bits, mark full, steer to the free buffer
  always_comb begin
    buf_d     = buf_q;
    full_d    = full_q;
    fsel_d    = fsel_q;
    wcnt_d    = wcnt_q;
    accept    = Valid_in && Ready_out;
    fill_done = accept && (wcnt_q == LAST);
    if (accept) begin
      buf_d[fsel_q][wcnt_q] = Data_in;
      wcnt_d = fill_done ? '0 : wcnt_q + 1'b1;
    end
    if (fill_done) full_d[fsel_q] = 1'b1;
    if (rd_done) full_d[rsel_q] = 1'b0;
    if (full_d[fsel_q] && !full_d[~fsel_q]) fsel_d = ~fsel_q;
  end

  // Read FSM: preload tail-biting state, then emit X/Y pairs
  always_comb begin
    state_d    = state_q;
    rsel_d     = rsel_q;
    rcnt_d     = rcnt_q;
    ph_d       = ph_q;
    sr_d       = sr_q;
    vld_d      = vld_q;
    dat_d      = dat_q;
    rd_done    = 1'b0;
    rd_buf     = buf_q[rsel_q];
    xfer       = vld_q && Ready_in;
    rcnt_nx    = rcnt_q + 1'b1;
    cur_u      = rd_buf[rcnt_q];
    nxt_u      = (rcnt_q == LAST) ? 1'b0 : rd_buf[rcnt_nx];
    nxt_sr     = {sr_q[4:0], cur_u};
    other_full = full_q[~rsel_q] || (fill_done && (fsel_q == ~rsel_q));
    for (int k = 0; k < 6; k++) ld_sr[k] = rd_buf[N_BLK-1-k];
    ld_xy  = enc(rd_buf[0], ld_sr);
    cur_xy = enc(cur_u, sr_q);
    nxt_xy = enc(nxt_u, nxt_sr);
    case (state_q)
      IDLE: begin
        if (full_q[rsel_q]) state_d = LOAD;
      end
      LOAD: begin
        sr_d    = ld_sr;
        rcnt_d  = '0;
        ph_d    = 1'b0;
        dat_d   = ld_xy[1];
        vld_d   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (xfer && !ph_q) begin
          ph_d  = 1'b1;
          dat_d = cur_xy[0];
        end else if (xfer) begin
          ph_d = 1'b0;
          sr_d = nxt_sr;
          if (rcnt_q == LAST) begin
            rd_done = 1'b1;
            vld_d   = 1'b0;
            dat_d   = 1'b0;
            rcnt_d  = '0;
            rsel_d  = ~rsel_q;
            state_d = other_full ? LOAD : IDLE;
          end else begin
            rcnt_d = rcnt_nx;
            dat_d  = nxt_xy[1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      full_q  <= '0;
      fsel_q  <= 1'b0;
      wcnt_q  <= '0;
      rsel_q  <= 1'b0;
      rcnt_q  <= '0;
      ph_q    <= 1'b0;
      sr_q    <= '0;
      vld_q   <= 1'b0;
      dat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      fsel_q  <= fsel_d;
      wcnt_q  <= wcnt_d;
      rsel_q  <= rsel_d;
      rcnt_q  <= rcnt_d;
      ph_q    <= ph_d;
      sr_q    <= sr_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end

endmodule

// File: tb/tb_fec_encoder.sv
// Scoreboard bench for fec_encoder.
// Golden tail-biting model fills a queue; the monitor pops per transfer.
module tb_fec_encoder;
  localparam int N = 96;

  logic clk = 1'b0;
  logic rst, Valid_in, Data_in, Ready_in;
  logic Ready_out, Valid_out, Data_out;

  int n_chk = 0;
  int n_fail = 0;
  logic exp_q[$];
  int out_cnt = 0;
  logic [13:0] hist = '0;
  logic held = 1'b0;
  logic hold_d = 1'b0;
  logic saw_full = 1'b0;
  logic rnd_rdy = 1'b0;

  fec_encoder #(.N_BLK(N)) dut (
    .clk(clk),
    .rst(rst),
    .Valid_in(Valid_in),
    .Data_in(Data_in),
    .Ready_out(Ready_out),
    .Ready_in(Ready_in),
    .Valid_out(Valid_out),
    .Data_out(Data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input logic [N-1:0] b);
    logic u, x, y;
    logic [6:1] s;
    for (int i = 0; i < N; i++) begin
      u = b[i];
      for (int k = 1; k <= 6; k++) s[k] = b[(i - k + N) % N];
      x = u ^ s[1] ^ s[2] ^ s[3] ^ s[6];
      y = u ^ s[2] ^ s[3] ^ s[5] ^ s[6];
      exp_q.push_back(x);
      exp_q.push_back(y);
    end
  endfunction

  // Monitor: score transfers, check stall stability
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid", 32'(Valid_out), 32'd1);
        chk("stall_data", 32'(Data_out), 32'(hold_d));
      end
      if (Valid_out && Ready_in) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          chk("data", 32'(Data_out), 32'(exp_q.pop_front()));
        end
        if (out_cnt < 14) hist = {hist[12:0], Data_out};
        out_cnt++;
      end
      held = Valid_out && !Ready_in;
      hold_d = Data_out;
    end
  end

  // Random downstream backpressure
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1 Ready_in = 1'($urandom_range(1));
    end
  end

  task automatic send_bit(input logic b, input int gap_pct);
    int w;
    if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      Valid_in = 1'b0;
      @(posedge clk);
      #1;
    end
    Valid_in = 1'b1;
    Data_in = b;
    w = 0;
    @(negedge clk);
    while (!Ready_out && w < 2000) begin
      saw_full = 1'b1;
      w++;
      @(negedge clk);
    end
    if (w >= 2000) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    Valid_in = 1'b0;
  endtask

  task automatic send_block(input logic [N-1:0] b, input int gap_pct);
    for (int i = 0; i < N; i++) begin
      send_bit(b[i], gap_pct);
      if (i == N - 1) push_exp(b);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    #3 rst = 1'b1;
    Valid_in = 1'b0;
    #1;
    chk("rst_valid", 32'(Valid_out), 32'd0);
    chk("rst_data", 32'(Data_out), 32'd0);
    chk("rst_ready", 32'(Ready_out), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(Ready_out), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] blk;
    logic [13:0] h;
    int run, w;
    rst = 1'b1;
    Valid_in = 1'b0;
    Data_in = 1'b0;
    Ready_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(Valid_out), 32'd0);
    chk("reset_data", 32'(Data_out), 32'd0);
    chk("reset_ready", 32'(Ready_out), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_first", 32'(Ready_out), 32'd1);
    @(posedge clk);
    #1;

    // all-zero block: latency and continuous output
    blk = '0;
    send_block(blk, 0);
    @(negedge clk);
    chk("lat_c1", 32'(Valid_out), 32'd0);
    @(negedge clk);
    chk("lat_c2", 32'(Valid_out), 32'd0);
    @(negedge clk);
    chk("lat_c3", 32'(Valid_out), 32'd1);
    run = 0;
    while (Valid_out && run < 300) begin
      run++;
      @(negedge clk);
    end
    chk("run_len", 32'(run), 32'd192);
    drain();

    // impulse at bit 0
    out_cnt = 0;
    blk = '0;
    blk[0] = 1'b1;
    send_block(blk, 0);
    drain();
    chk("imp0_head", 32'(hist), 32'(14'b11101111000111));

    // impulse at bit N-1 wraps into the head
    out_cnt = 0;
    blk = '0;
    blk[N-1] = 1'b1;
    send_block(blk, 0);
    drain();
    h = hist;
    chk("imp95_head", 32'(h[13:2]), 32'(12'b101111000111));

    // back-to-back blocks force both buffers full
    saw_full = 1'b0;
    for (int j = 0; j < 3; j++) begin
      blk = {$urandom, $urandom, $urandom};
      send_block(blk, 0);
    end
    chk("ready_dropped", 32'(saw_full), 32'd1);
    drain();

    // random backpressure with input gaps
    rnd_rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      blk = {$urandom, $urandom, $urandom};
      send_block(blk, 30);
    end
    drain();
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1;
    Ready_in = 1'b1;

    // reset mid-fill
    blk = {$urandom, $urandom, $urandom};
    for (int i = 0; i < 50; i++) send_bit(blk[i], 0);
    pulse_rst();
    blk = {$urandom, $urandom, $urandom};
    send_block(blk, 0);
    drain();

    // reset during output
    blk = {$urandom, $urandom, $urandom};
    send_block(blk, 0);
    out_cnt = 0;
    w = 0;
    while (out_cnt < 20 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("mid_out_wait", 32'(out_cnt >= 20), 32'd1);
    @(posedge clk);
    #1;
    pulse_rst();
    blk = {$urandom, $urandom, $urandom};
    send_block(blk, 0);
    drain();

    repeat (300) @(posedge clk);
    #1;
    chk("idle_quiet", 32'(Valid_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
